// File: rtl/axil_reg_bank.sv
// AXI4-Lite register bank exposing ID, SCRATCH, CTRL, STATUS, PULSE and CYCLES.
// The write (AW/W/B) and read (AR/R) channels run independently, one access outstanding each.

module axil_reg_bank #(
    parameter logic [31:0] ID_VALUE    = 32'h4C50_0001,
    parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [14:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [14:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] status_in,
    output logic [31:0] ctrl_out,
    output logic [31:0] pulse_out
);

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned IDX_W  = ADDR_W - 2;

    localparam logic [IDX_W-1:0] IDX_ID      = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_SCRATCH = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_CTRL    = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_STATUS  = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_PULSE   = IDX_W'(4);
    localparam logic [IDX_W-1:0] IDX_CYCLES  = IDX_W'(5);

    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;
    localparam logic [DATA_W-1:0] BAD_DATA    = 32'hBADA_DD00;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_ADDR,
        WR_DATA,
        WR_COMMIT,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_VALID
    } rd_state_t;

    wr_state_t wr_state_q, wr_state_d;
    rd_state_t rd_state_q, rd_state_d;

    logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0] w_strb_q, w_strb_d;

    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [DATA_W-1:0] scratch_q, scratch_d;
    logic [DATA_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] cycles_q, cycles_d;
    logic [DATA_W-1:0] pulse_q, pulse_d;

    logic              aw_hs;
    logic              w_hs;
    logic              ar_hs;
    logic [DATA_W-1:0] w_mask;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data_c;
    logic [1:0]        rd_resp_c;
    logic              unused_addr_lsbs;

    // Byte lanes are addressed by the word index only; the low address bits carry no meaning.
    assign unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};

    assign aw_hs  = awvalid & awready_q;
    assign w_hs   = wvalid & wready_q;
    assign ar_hs  = arvalid & arready_q;
    assign rd_idx = araddr[ADDR_W-1:2];

    always_comb begin
        for (int i = 0; i < int'(STRB_W); i++) begin
            w_mask[i*8 +: 8] = {8{w_strb_q[i]}};
        end
    end

    // Read data mux, sampled into rdata on the AR handshake.
    always_comb begin
        rd_data_c = BAD_DATA;
        rd_resp_c = RESP_SLVERR;
        case (rd_idx)
            IDX_ID:      begin rd_data_c = ID_VALUE;  rd_resp_c = RESP_OKAY; end
            IDX_SCRATCH: begin rd_data_c = scratch_q; rd_resp_c = RESP_OKAY; end
            IDX_CTRL:    begin rd_data_c = ctrl_q;    rd_resp_c = RESP_OKAY; end
            IDX_STATUS:  begin rd_data_c = status_in; rd_resp_c = RESP_OKAY; end
            IDX_PULSE:   begin rd_data_c = '0;        rd_resp_c = RESP_OKAY; end
            IDX_CYCLES:  begin rd_data_c = cycles_q;  rd_resp_c = RESP_OKAY; end
            default:     ;
        endcase
    end

    // Write channel: collect AW and W in any order, commit one cycle later, then respond.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_idx_d   = aw_idx_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bresp_d    = bresp_q;
        scratch_d  = scratch_q;
        ctrl_d     = ctrl_q;
        cycles_d   = cycles_q + DATA_W'(1);
        pulse_d    = '0;

        if (aw_hs) begin
            aw_idx_d = awaddr[ADDR_W-1:2];
        end
        if (w_hs) begin
            w_data_d = wdata;
            w_strb_d = wstrb;
        end

        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_state_d = WR_COMMIT;
                end else if (aw_hs) begin
                    wr_state_d = WR_ADDR;
                end else if (w_hs) begin
                    wr_state_d = WR_DATA;
                end
            end
            WR_ADDR: begin
                if (w_hs) begin
                    wr_state_d = WR_COMMIT;
                end
            end
            WR_DATA: begin
                if (aw_hs) begin
                    wr_state_d = WR_COMMIT;
                end
            end
            WR_COMMIT: begin
                wr_state_d = WR_RESP;
                bresp_d    = (aw_idx_q <= IDX_CYCLES) ? RESP_OKAY : RESP_SLVERR;
                case (aw_idx_q)
                    IDX_SCRATCH: scratch_d = (scratch_q & ~w_mask) | (w_data_q & w_mask);
                    IDX_CTRL:    ctrl_d    = (ctrl_q & ~w_mask) | (w_data_q & w_mask);
                    IDX_PULSE:   pulse_d   = w_data_q & w_mask;
                    IDX_CYCLES:  cycles_d  = '0;
                    default:     ;
                endcase
            end
            WR_RESP: begin
                if (bready) begin
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase

        awready_d = (wr_state_d == WR_IDLE) || (wr_state_d == WR_DATA);
        wready_d  = (wr_state_d == WR_IDLE) || (wr_state_d == WR_ADDR);
        bvalid_d  = (wr_state_d == WR_RESP);
    end

    // Read channel: arready is withheld for the whole cycle rvalid is up.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;

        case (rd_state_q)
            RD_IDLE: begin
                if (ar_hs) begin
                    rd_state_d = RD_VALID;
                    rdata_d    = rd_data_c;
                    rresp_d    = rd_resp_c;
                end
            end
            RD_VALID: begin
                if (rready) begin
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase

        arready_d = (rd_state_d == RD_IDLE);
        rvalid_d  = (rd_state_d == RD_VALID);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            aw_idx_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= '0;
            rdata_q    <= '0;
            scratch_q  <= SCRATCH_RST;
            ctrl_q     <= '0;
            cycles_q   <= '0;
            pulse_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            aw_idx_q   <= aw_idx_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            scratch_q  <= scratch_d;
            ctrl_q     <= ctrl_d;
            cycles_q   <= cycles_d;
            pulse_q    <= pulse_d;
        end
    end

    assign awready   = awready_q;
    assign wready    = wready_q;
    assign bvalid    = bvalid_q;
    assign bresp     = bresp_q;
    assign arready   = arready_q;
    assign rvalid    = rvalid_q;
    assign rresp     = rresp_q;
    assign rdata     = rdata_q;
    assign ctrl_out  = ctrl_q;
    assign pulse_out = pulse_q;

endmodule

// File: tb/tb_axil_reg_bank.sv
// Self-checking bench for axil_reg_bank: expected responses are queued as stimulus is issued
// and compared against the responses collected from the bus.

module tb_axil_reg_bank;

    localparam logic [31:0] ID_VALUE    = 32'h4C50_0001;
    localparam logic [31:0] SCRATCH_RST = 32'h1357_9BDF;
    localparam logic [31:0] BAD_DATA    = 32'hBADA_DD00;
    localparam logic [1:0]  OKAY        = 2'b00;
    localparam logic [1:0]  SLVERR      = 2'b10;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [14:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [14:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [31:0] status_in = '0;
    logic [31:0] ctrl_out;
    logic [31:0] pulse_out;

    int total = 0;
    int bad = 0;

    logic [1:0]  exp_b[$];
    logic [1:0]  obs_b[$];
    logic [33:0] exp_r[$];
    logic [33:0] obs_r[$];
    logic [31:0] scratch_m;
    logic [31:0] ctrl_m;

    axil_reg_bank #(
        .ID_VALUE    (ID_VALUE),
        .SCRATCH_RST (SCRATCH_RST)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rvalid    (rvalid),
        .rready    (rready),
        .status_in (status_in),
        .ctrl_out  (ctrl_out),
        .pulse_out (pulse_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{s[i]}};
        return (old & ~m) | (d & m);
    endfunction

    // Bus driver: one write, observed bresp appended to obs_b (x on timeout).
    task automatic axi_write(input logic [14:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_done = 1'b0;
        bit w_done = 1'b0;
        bit aw_hs;
        bit w_hs;
        int n = 0;
        @(negedge clk);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(negedge clk); n++;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin wvalid = 1'b0;  w_done = 1'b1;  end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        while (!bvalid && n < 100) begin @(negedge clk); n++; end
        if (bvalid) begin
            obs_b.push_back(bresp);
            @(negedge clk);
        end else begin
            obs_b.push_back(2'bxx);
        end
    endtask

    // Bus driver: one read, observed {rresp, rdata} appended to obs_r (x on timeout).
    task automatic axi_read(input logic [14:0] a);
        bit done = 1'b0;
        bit hs;
        int n = 0;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        while (!done && n < 50) begin
            hs = arvalid && arready;
            @(negedge clk); n++;
            if (hs) begin arvalid = 1'b0; done = 1'b1; end
        end
        arvalid = 1'b0;
        while (!rvalid && n < 100) begin @(negedge clk); n++; end
        if (rvalid) begin
            obs_r.push_back({rresp, rdata});
            @(negedge clk);
        end else begin
            obs_r.push_back({34{1'bx}});
        end
    endtask

    task automatic test_reset();
        logic [1:0] be, bo;
        logic [33:0] re, ro;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({awready, wready, arready} !== 3'b000) begin
            bad++; $display("FAIL reset_ready got=%b want=000", {awready, wready, arready});
        end
        total++;
        if ({bvalid, rvalid, bresp, rresp} !== 6'b0) begin
            bad++; $display("FAIL reset_valid_resp got=%b want=000000", {bvalid, rvalid, bresp, rresp});
        end
        total++;
        if ({rdata, ctrl_out, pulse_out} !== 96'b0) begin
            bad++; $display("FAIL reset_data got=%h/%h/%h want=0", rdata, ctrl_out, pulse_out);
        end
        rstn = 1'b1;
        @(negedge clk);
        total++;
        if ({awready, wready, arready} !== 3'b111) begin
            bad++; $display("FAIL post_reset_ready got=%b want=111", {awready, wready, arready});
        end
        scratch_m = SCRATCH_RST;
        ctrl_m = '0;
        exp_r.push_back({OKAY, ID_VALUE}); axi_read(15'h0000);
        exp_r.push_back({OKAY, SCRATCH_RST}); axi_read(15'h0004);
        exp_r.push_back({OKAY, 32'h0}); axi_read(15'h0008);
        while (exp_r.size() > 0) begin
            re = exp_r.pop_front(); ro = obs_r.pop_front(); total++;
            if (ro !== re) begin bad++; $display("FAIL reset_read got=%h want=%h", ro, re); end
        end
        while (exp_b.size() > 0) begin
            be = exp_b.pop_front(); bo = obs_b.pop_front(); total++;
            if (bo !== be) begin bad++; $display("FAIL reset_bresp got=%h want=%h", bo, be); end
        end
    endtask

    task automatic test_scratch();
        logic [1:0] be, bo;
        logic [33:0] re, ro;
        exp_b.push_back(OKAY); axi_write(15'h0004, 32'hA5A5_1234, 4'hF);
        scratch_m = 32'hA5A5_1234;
        exp_r.push_back({OKAY, 32'hA5A5_1234}); axi_read(15'h0004);
        while (exp_b.size() > 0) begin
            be = exp_b.pop_front(); bo = obs_b.pop_front(); total++;
            if (bo !== be) begin bad++; $display("FAIL scratch_bresp got=%h want=%h", bo, be); end
        end
        while (exp_r.size() > 0) begin
            re = exp_r.pop_front(); ro = obs_r.pop_front(); total++;
            if (ro !== re) begin bad++; $display("FAIL scratch_read got=%h want=%h", ro, re); end
        end
    endtask

    task automatic test_strobe();
        logic [1:0] be, bo;
        logic [33:0] re, ro;
        exp_b.push_back(OKAY); axi_write(15'h0004, 32'h1111_1111, 4'hF);
        exp_b.push_back(OKAY); axi_write(15'h0004, 32'hFFFF_FFFF, 4'b0101);
        scratch_m = 32'h11FF_11FF;
        exp_r.push_back({OKAY, 32'h11FF_11FF}); axi_read(15'h0004);
        exp_b.push_back(OKAY); axi_write(15'h0008, 32'h0000_0000, 4'hF);
        exp_b.push_back(OKAY); axi_write(15'h0008, 32'hABCD_EF01, 4'b1000);
        exp_b.push_back(OKAY); axi_write(15'h0008, 32'h5566_7788, 4'b0010);
        ctrl_m = 32'hAB00_7700;
        exp_r.push_back({OKAY, ctrl_m}); axi_read(15'h0008);
        total++;
        if (ctrl_out !== 32'hAB00_7700) begin
            bad++; $display("FAIL strobe_ctrl_out got=%h want=%h", ctrl_out, 32'hAB00_7700);
        end
        while (exp_b.size() > 0) begin
            be = exp_b.pop_front(); bo = obs_b.pop_front(); total++;
            if (bo !== be) begin bad++; $display("FAIL strobe_bresp got=%h want=%h", bo, be); end
        end
        while (exp_r.size() > 0) begin
            re = exp_r.pop_front(); ro = obs_r.pop_front(); total++;
            if (ro !== re) begin bad++; $display("FAIL strobe_read got=%h want=%h", ro, re); end
        end
    endtask

    task automatic test_w_before_aw();
        int bcnt = 0;
        int rdy_hi = 0;
        int pcnt = 0;
        logic [1:0] be, bo;
        @(negedge clk);
        bready = 1'b0; wdata = 32'h0000_005A; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        total++;
        if ({awready, wready} !== 2'b10) begin
            bad++; $display("FAIL w_held_ready got=%b want=10", {awready, wready});
        end
        repeat (2) @(negedge clk);
        awaddr = 15'h0010; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            bcnt += int'(bvalid);
            rdy_hi += int'(awready | wready);
            pcnt += int'(pulse_out == 32'h0000_005A);
        end
        exp_b.push_back(OKAY);
        obs_b.push_back(bvalid ? bresp : 2'bxx);
        bready = 1'b1;
        @(negedge clk);
        total++;
        if (bcnt !== 5) begin bad++; $display("FAIL w_first_bvalid_cycles got=%0d want=5", bcnt); end
        total++;
        if (rdy_hi !== 0) begin bad++; $display("FAIL w_first_ready_during_b got=%0d want=0", rdy_hi); end
        total++;
        if (pcnt !== 1) begin bad++; $display("FAIL w_first_single_update got=%0d want=1", pcnt); end
        total++;
        if ({bvalid, awready, wready} !== 3'b011) begin
            bad++; $display("FAIL w_first_after_b got=%b want=011", {bvalid, awready, wready});
        end
        while (exp_b.size() > 0) begin
            be = exp_b.pop_front(); bo = obs_b.pop_front(); total++;
            if (bo !== be) begin bad++; $display("FAIL w_first_bresp got=%h want=%h", bo, be); end
        end
    endtask

    task automatic test_unmapped();
        logic [1:0] be, bo;
        logic [33:0] re, ro;
        exp_b.push_back(OKAY); axi_write(15'h0008, 32'h1234_5678, 4'hF);
        ctrl_m = 32'h1234_5678;
        exp_b.push_back(SLVERR); axi_write(15'h0040, 32'hFFFF_FFFF, 4'hF);
        exp_b.push_back(SLVERR); axi_write(15'h0018, 32'hFFFF_FFFF, 4'hF);
        exp_r.push_back({SLVERR, BAD_DATA}); axi_read(15'h7FFC);
        exp_r.push_back({SLVERR, BAD_DATA}); axi_read(15'h0018);
        exp_r.push_back({OKAY, ctrl_m}); axi_read(15'h0008);
        total++;
        if (ctrl_out !== ctrl_m) begin
            bad++; $display("FAIL unmapped_ctrl_out got=%h want=%h", ctrl_out, ctrl_m);
        end
        while (exp_b.size() > 0) begin
            be = exp_b.pop_front(); bo = obs_b.pop_front(); total++;
            if (bo !== be) begin bad++; $display("FAIL unmapped_bresp got=%h want=%h", bo, be); end
        end
        while (exp_r.size() > 0) begin
            re = exp_r.pop_front(); ro = obs_r.pop_front(); total++;
            if (ro !== re) begin bad++; $display("FAIL unmapped_read got=%h want=%h", ro, re); end
        end
    endtask

    task automatic test_ro_regs();
        logic [1:0] be, bo;
        logic [33:0] re, ro;
        exp_b.push_back(OKAY); axi_write(15'h0000, 32'h0000_0000, 4'hF);
        exp_b.push_back(OKAY); axi_write(15'h000C, 32'hFFFF_FFFF, 4'hF);
        status_in = 32'hCAFE_F00D;
        exp_r.push_back({OKAY, ID_VALUE});     axi_read(15'h0000);
        exp_r.push_back({OKAY, 32'hCAFE_F00D}); axi_read(15'h000C);
        exp_r.push_back({OKAY, 32'h0});         axi_read(15'h0010);
        exp_r.push_back({OKAY, scratch_m});     axi_read(15'h0007);
        while (exp_b.size() > 0) begin
            be = exp_b.pop_front(); bo = obs_b.pop_front(); total++;
            if (bo !== be) begin bad++; $display("FAIL ro_bresp got=%h want=%h", bo, be); end
        end
        while (exp_r.size() > 0) begin
            re = exp_r.pop_front(); ro = obs_r.pop_front(); total++;
            if (ro !== re) begin bad++; $display("FAIL ro_read got=%h want=%h", ro, re); end
        end
    endtask

    task automatic test_pulse_cycles();
        int pcnt = 0;
        logic [31:0] pval = '0;
        logic [1:0] be, bo;
        logic [33:0] ro;
        exp_b.push_back(OKAY);
        fork
            axi_write(15'h0010, 32'h0000_0081, 4'hF);
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (pulse_out !== 32'h0) begin pcnt++; pval = pulse_out; end
            end
        join
        total++;
        if (pcnt !== 1 || pval !== 32'h0000_0081) begin
            bad++; $display("FAIL pulse_full got=%0d x %h want=1 x 00000081", pcnt, pval);
        end
        pcnt = 0; pval = '0;
        exp_b.push_back(OKAY);
        fork
            axi_write(15'h0010, 32'hFFFF_FFFF, 4'b0010);
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (pulse_out !== 32'h0) begin pcnt++; pval = pulse_out; end
            end
        join
        total++;
        if (pcnt !== 1 || pval !== 32'h0000_FF00) begin
            bad++; $display("FAIL pulse_strobe got=%0d x %h want=1 x 0000ff00", pcnt, pval);
        end
        repeat (60) @(negedge clk);
        axi_read(15'h0014);
        ro = obs_r.pop_front();
        total++;
        if (ro[33:32] !== OKAY || ro[31:0] < 32'd60) begin
            bad++; $display("FAIL cycles_running got=%h want>=60 resp 0", ro);
        end
        exp_b.push_back(OKAY); axi_write(15'h0014, 32'hFFFF_FFFF, 4'b0001);
        repeat (10) @(negedge clk);
        axi_read(15'h0014);
        ro = obs_r.pop_front();
        total++;
        if (ro[33:32] !== OKAY || ro[31:0] >= 32'd16 || ro[31:0] < 32'd10) begin
            bad++; $display("FAIL cycles_cleared got=%h want 10..15 resp 0", ro);
        end
        while (exp_b.size() > 0) begin
            be = exp_b.pop_front(); bo = obs_b.pop_front(); total++;
            if (bo !== be) begin bad++; $display("FAIL pulse_bresp got=%h want=%h", bo, be); end
        end
    endtask

    task automatic test_concurrent();
        logic [1:0] be, bo;
        logic [33:0] re, ro;
        exp_b.push_back(OKAY); axi_write(15'h0004, 32'h0BAD_F00D, 4'hF);
        exp_b.push_back(OKAY);
        exp_r.push_back({OKAY, 32'h0BAD_F00D});
        fork
            axi_write(15'h0004, 32'h600D_CAFE, 4'hF);
            axi_read(15'h0004);
        join
        scratch_m = 32'h600D_CAFE;
        exp_r.push_back({OKAY, scratch_m}); axi_read(15'h0004);
        while (exp_b.size() > 0) begin
            be = exp_b.pop_front(); bo = obs_b.pop_front(); total++;
            if (bo !== be) begin bad++; $display("FAIL concurrent_bresp got=%h want=%h", bo, be); end
        end
        while (exp_r.size() > 0) begin
            re = exp_r.pop_front(); ro = obs_r.pop_front(); total++;
            if (ro !== re) begin bad++; $display("FAIL concurrent_read got=%h want=%h", ro, re); end
        end
    endtask

    task automatic test_back_to_back();
        int hs = 0;
        int overlap = 0;
        int data_err = 0;
        logic [31:0] d;
        logic [1:0] be, bo;
        logic [33:0] re, ro;
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            exp_b.push_back(OKAY);
            if (i[0]) begin
                axi_write(15'h0008, d, 4'(i + 5));
                ctrl_m = merge(ctrl_m, d, 4'(i + 5));
                exp_r.push_back({OKAY, ctrl_m});
            end else begin
                axi_write(15'h0004, d, 4'(i + 5));
                scratch_m = merge(scratch_m, d, 4'(i + 5));
                exp_r.push_back({OKAY, scratch_m});
            end
            axi_read(i[0] ? 15'h0008 : 15'h0004);
        end
        @(negedge clk);
        araddr = 15'h0004; arvalid = 1'b1; rready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            hs += int'(arvalid && arready);
            overlap += int'(rvalid && arready);
            data_err += int'(rvalid && (rdata !== scratch_m));
            @(negedge clk);
        end
        arvalid = 1'b0;
        @(negedge clk);
        total++;
        if (hs !== 10) begin bad++; $display("FAIL b2b_read_rate got=%0d want=10", hs); end
        total++;
        if (overlap !== 0) begin bad++; $display("FAIL b2b_arready_with_rvalid got=%0d want=0", overlap); end
        total++;
        if (data_err !== 0) begin bad++; $display("FAIL b2b_burst_data got=%0d want=0", data_err); end
        while (exp_b.size() > 0) begin
            be = exp_b.pop_front(); bo = obs_b.pop_front(); total++;
            if (bo !== be) begin bad++; $display("FAIL b2b_bresp got=%h want=%h", bo, be); end
        end
        while (exp_r.size() > 0) begin
            re = exp_r.pop_front(); ro = obs_r.pop_front(); total++;
            if (ro !== re) begin bad++; $display("FAIL b2b_read got=%h want=%h", ro, re); end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int bcnt = 0;
        logic [33:0] re, ro;
        @(negedge clk);
        bready = 1'b0;
        awaddr = 15'h0008; awvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        total++;
        if ({bvalid, ctrl_out} !== {1'b1, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL mid_before_reset got=%b/%h want=1/deadbeef", bvalid, ctrl_out);
        end
        rstn = 1'b0;
        #1;
        total++;
        if ({bvalid, ctrl_out, awready, arready} !== 35'b0) begin
            bad++; $display("FAIL mid_async_reset got=%b/%h/%b/%b want=0", bvalid, ctrl_out, awready, arready);
        end
        @(negedge clk);
        rstn = 1'b1;
        bready = 1'b1;
        repeat (4) begin @(negedge clk); bcnt += int'(bvalid); end
        total++;
        if (bcnt !== 0) begin bad++; $display("FAIL mid_no_resp_after got=%0d want=0", bcnt); end
        scratch_m = SCRATCH_RST;
        ctrl_m = '0;
        // An address held across reset must be forgotten: a lone W afterwards cannot complete.
        awaddr = 15'h0004; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        wdata = 32'h7777_7777; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        bcnt = 0;
        repeat (6) begin @(negedge clk); bcnt += int'(bvalid); end
        total++;
        if (bcnt !== 0) begin bad++; $display("FAIL mid_held_aw_discarded got=%0d want=0", bcnt); end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        exp_r.push_back({OKAY, ID_VALUE});    axi_read(15'h0000);
        exp_r.push_back({OKAY, 32'h0});       axi_read(15'h0008);
        exp_r.push_back({OKAY, SCRATCH_RST}); axi_read(15'h0004);
        while (exp_r.size() > 0) begin
            re = exp_r.pop_front(); ro = obs_r.pop_front(); total++;
            if (ro !== re) begin bad++; $display("FAIL mid_read_after got=%h want=%h", ro, re); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scratch();
        test_strobe();
        test_w_before_aw();
        test_unmapped();
        test_ro_regs();
        test_pulse_cycles();
        test_concurrent();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axil_reg_bank.md
AXIL_REG_BANK -- requirements
Module: axil_reg_bank

Interface
REQ-001 SHALL have parameter ID_VALUE, default 32'h4C50_0001, value returned by the ID register.
REQ-002 SHALL have parameter SCRATCH_RST, default 32'h0000_0000, reset value of SCRATCH.
REQ-003 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports awaddr/awvalid/awready  in/in/out  15/1/1  AXI-Lite write address.
REQ-006 SHALL have ports wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  AXI-Lite write data.
REQ-007 SHALL have ports bresp/bvalid/bready  out/out/in  2/1/1  AXI-Lite write response.
REQ-008 SHALL have ports araddr/arvalid/arready  in/in/out  15/1/1  AXI-Lite read address.
REQ-009 SHALL have ports rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  AXI-Lite read data.
REQ-010 SHALL have port status_in  input  32  live status, sampled on read.
REQ-011 SHALL have port ctrl_out  output  32  CTRL register contents.
REQ-012 SHALL have port pulse_out  output  32  one-cycle strobes from PULSE writes.

Function
REQ-013 Register map (word index = addr[14:2], addr[1:0] ignored): 0x00 ID RO; 0x04 SCRATCH RW; 0x08 CTRL RW; 0x0C STATUS RO; 0x10 PULSE WO; 0x14 CYCLES RO, write clears.
REQ-014 RW writes SHALL honour wstrb per byte; bytes with strobe 0 unchanged.
REQ-015 Write path: awready=1 while no AW held and bvalid=0; wready=1 while no W held and bvalid=0; AW and W accepted independently, in either order or same cycle.
REQ-016 When AW and W both held, register update SHALL occur on that edge's next cycle and bvalid SHALL rise the same cycle; held AW/W released then.
REQ-017 bvalid/bresp SHALL stay stable until bready=1; bvalid falls the cycle after the handshake; no new AW/W accepted while bvalid=1.
REQ-018 Read path: arready=1 iff rvalid=0; on AR handshake rvalid=1 next cycle with rdata/rresp registered; stable until rready=1.
REQ-019 Simultaneous rvalid&rready and arvalid: arready stays 0 that cycle; next AR accepted the following cycle (max one read per two cycles).
REQ-020 Read and write channels SHALL operate concurrently; a same-cycle read and write to SCRATCH returns the pre-write value.
REQ-021 Unmapped address: write has no effect, bresp=2'b10; read rdata=32'hBADA_DD00, rresp=2'b10. Mapped accesses: resp 2'b00.
REQ-022 Writes to ID or STATUS: no effect, bresp=2'b00; reads of PULSE return 0.
REQ-023 PULSE write SHALL drive pulse_out = wdata & strobe mask for exactly one cycle, then 0.
REQ-024 CYCLES SHALL increment by 1 every clk, wrap 32'hFFFF_FFFF -> 0; a write (any data/strobe) loads 0 on the update cycle, increment resumes next cycle.
REQ-025 STATUS read SHALL return status_in sampled on the AR handshake cycle.
REQ-026 ctrl_out SHALL be driven directly from the CTRL register (no extra latency after update).

Reset
REQ-027 On rstn low, asynchronously: awready=wready=arready=0 then 1 from first cycle after release; bvalid=rvalid=0; bresp=rresp=0; rdata=0; pulse_out=0; ctrl_out=0; SCRATCH=SCRATCH_RST; CYCLES=0; held AW/W discarded.
REQ-028 Reset asserted mid-transaction SHALL abort it: no register update, no response issued afterwards.

Verification
REQ-029 Write 0x04 data 32'hA5A5_1234 wstrb 4'hF, then read 0x04 -> bresp 0, rdata 32'hA5A5_1234, rresp 0.
REQ-030 SCRATCH=32'h1111_1111, write 32'hFFFF_FFFF wstrb 4'b0101 -> read 32'h11FF_11FF.
REQ-031 W presented 3 cycles before AW, bready held 0 for 5 cycles -> single update, bvalid held 5 cycles, awready/wready 0 meanwhile.
REQ-032 Read 0x7FFC and write 0x0040 -> rdata 32'hBADA_DD00 rresp 2'b10, bresp 2'b10, CTRL unchanged.
REQ-033 Write 0x10 data 32'h0000_0081 -> pulse_out 32'h0000_0081 for exactly one cycle; write 0x14, read 0x14 ten cycles later -> small value (<16), confirming clear.
REQ-034 Assert rstn during held bvalid with CTRL=32'hDEAD_BEEF -> bvalid=0, ctrl_out=0, read 0x00 after release returns ID_VALUE.
